// File: rtl/vid_timing_pkg.sv
// Shared timing defaults, FSM state type and counter sizing helper for the
// video timing reader.
package vid_timing_pkg;

  // 1280x720 @ 60 Hz (CEA-861) defaults
  localparam int DEF_H_ACTIVE   = 1280;
  localparam int DEF_H_FP       = 110;
  localparam int DEF_H_SYNC     = 40;
  localparam int DEF_H_BP       = 220;
  localparam int DEF_V_ACTIVE   = 720;
  localparam int DEF_V_FP       = 5;
  localparam int DEF_V_SYNC     = 5;
  localparam int DEF_V_BP       = 20;
  localparam bit DEF_SYNC_POL   = 1'b1;
  localparam int DEF_DATA_WIDTH = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A total of 1 would give a zero-width counter; keep at least one bit.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with wrap logic and the combinational
// decode of data-enable, sync windows and frame boundary markers.
module vid_timing_cnt
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic de,
  output logic hs,
  output logic vs,
  output logic frame_first,
  output logic frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  // Counters sit at the origin whenever the raster is not running, so the
  // first RUN cycle always presents pixel (0,0).
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Compare in int so window ends equal to the total cannot overflow HW/VW.
  always_comb begin
    de          = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs          = (int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END);
    vs          = (int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END);
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    frame_last  = h_last && v_last;
  end

endmodule

// File: rtl/vid_timing_reader.sv
// Video timing generator that drains a show-ahead pixel FIFO during active
// video, emitting registered sync/DE/data with sticky underflow detection.
module vid_timing_reader
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = DEF_SYNC_POL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  vid_de,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  frame_start,
  output logic                  underflow,
  input  logic                  underflow_clr
);

  state_t state;
  logic   de_i;
  logic   hs_i;
  logic   vs_i;
  logic   frame_first;
  logic   frame_last;
  logic   pix_ok;

  vid_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .run         (state == RUN),
    .de          (de_i),
    .hs          (hs_i),
    .vs          (vs_i),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  assign pix_ok = de_i & rd_vld;

  // The pop is masked during reset so the FIFO never loses a word to a
  // cycle whose pixel is discarded by the reset.
  assign rd_en = pix_ok & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vid_de      <= 1'b0;
      vid_hs      <= ~SYNC_POL;
      vid_vs      <= ~SYNC_POL;
      vid_data    <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en && rd_vld)       state <= RUN;
        RUN:  if (frame_last && !en)  state <= IDLE;
        default:                      state <= IDLE;
      endcase

      vid_de      <= de_i;
      vid_hs      <= hs_i ? SYNC_POL : ~SYNC_POL;
      vid_vs      <= vs_i ? SYNC_POL : ~SYNC_POL;
      vid_data    <= pix_ok ? rd_data : '0;
      frame_start <= de_i & frame_first;

      // A starved active pixel outranks a simultaneous clear.
      if (de_i && !rd_vld) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/vid_timing_reader.md
VID_TIMING_READER -- requirements
Module: vid_timing_reader

Interface
REQ-001 The parameters SHALL be, with default and meaning:
- H_ACTIVE, 1280, active pixels per line.
- H_FP, 110, horizontal front porch.
- H_SYNC, 40, horizontal sync width.
- H_BP, 220, horizontal back porch.
- V_ACTIVE, 720, active lines.
- V_FP, 5, vertical front porch.
- V_SYNC, 5, vertical sync width.
- V_BP, 20, vertical back porch.
- SYNC_POL, 1, asserted level of hs/vs.
- DATA_WIDTH, 24, pixel width (RGB888).

REQ-002 The ports SHALL be:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request.
- rd_vld  in  1  upstream prefetch FIFO has a word on rd_data.
- rd_data  in  DATA_WIDTH  show-ahead FIFO word.
- rd_en  out  1  pop the FIFO word (combinational).
- vid_hs  out  1  horizontal sync.
- vid_vs  out  1  vertical sync.
- vid_de  out  1  data enable.
- vid_data  out  DATA_WIDTH  pixel.
- frame_start  out  1  one-cycle pulse with the first pixel of each frame.
- underflow  out  1  sticky starvation flag.
- underflow_clr  in  1  clears underflow.

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal the vertical sum; counter widths SHALL be clog2 of each total.
REQ-004 The state machine SHALL have two states, IDLE and RUN.
REQ-005 IDLE -> RUN SHALL occur when en=1 and rd_vld=1; h_cnt and v_cnt SHALL be held at 0 in IDLE.
REQ-006 In RUN, h_cnt SHALL increment every cycle and wrap H_TOTAL-1 -> 0; v_cnt SHALL increment on each h_cnt wrap and wrap V_TOTAL-1 -> 0.
REQ-007 RUN -> IDLE SHALL occur only at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 with en=0; deasserting en mid-frame SHALL complete the current frame.
REQ-008 Internal de_i SHALL equal RUN & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
REQ-009 hs_i SHALL be active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_i SHALL be active for v_cnt in the equivalent vertical window.
REQ-010 rd_en SHALL equal de_i & rd_vld; no pop SHALL occur outside active video.
REQ-011 All video outputs SHALL be registered with latency 1 cycle from the counters: vid_de=de_i, vid_hs/vid_vs = SYNC_POL when active and ~SYNC_POL otherwise.
REQ-012 vid_data SHALL be rd_data when de_i & rd_vld, and 0 in all other cases.
REQ-013 An underflow cycle (de_i & !rd_vld) SHALL output a black pixel and SHALL NOT pop; the next active pixel SHALL use the next available word, with no skipping and no re-alignment.
REQ-014 underflow SHALL be set on any underflow cycle and cleared by underflow_clr; set SHALL win when both occur in the same cycle.
REQ-015 frame_start SHALL be registered high for one cycle, aligned with vid_de for h_cnt=0, v_cnt=0.

Reset
REQ-016 On rst the block SHALL enter IDLE and drive: counters 0, vid_de 0, vid_data 0, frame_start 0, underflow 0, vid_hs/vid_vs = ~SYNC_POL, rd_en 0.
REQ-017 rst asserted mid-frame SHALL take effect on the next edge regardless of state; after release, the block SHALL restart only via REQ-005.

Structure
REQ-018 Package vid_timing_pkg SHALL hold the default timing constants and a state enum (IDLE, RUN).
REQ-019 A sub-module vid_timing_cnt SHALL own the h/v counters, the wrap logic and the de_i/hs_i/vs_i decode; the top SHALL own the FSM, the FIFO handshake and the output registers.

Verification
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=7, V_TOTAL=5, frame=35 cycles) and SYNC_POL=1.
REQ-020 Reset with en=0 -> all outputs at reset values for 20 cycles, rd_en never high.
REQ-021 en=1, rd_vld=1, rd_data incrementing from 1:
- vid_data SHALL be 1,2,3,4 then 5,6,7,8 in the next line.
- rd_en SHALL pulse 8 times per frame.
- vid_hs SHALL be high 1 cycle per line, at h_cnt=5 plus latency.
- frame_start SHALL recur every 35 cycles.
REQ-022 rd_vld=0 during the 3rd pixel -> vid_data 0 in that slot, underflow=1, rd_en=0 that cycle, and the 4th slot SHALL carry word 3.
REQ-023 en dropped at h_cnt=2, v_cnt=0 -> frame runs to h_cnt=6, v_cnt=4, then IDLE, with no further rd_en.
REQ-024 underflow_clr asserted in the same cycle as a new underflow -> underflow stays 1; underflow_clr alone -> underflow goes 0 on the next cycle.
REQ-025 rst pulsed at h_cnt=3, v_cnt=1 -> next cycle shows reset values; re-entry to RUN only after en & rd_vld.
